csi_wr_sequencer: RTL
=====================

# csi_wr_sequencer

Write-side controller for the 20-bank dual-port line-buffer RAM in the CSI-2 to HDMI bridge. It sits between the 2-lane CSI-2 pixel-pair stream and the even/odd RAM bank arrays, in the write clock domain `clka`. It sub-samples the stream ("store 2, skip 2" on columns and lines) and generates registered bank select, address and write enables. It also publishes a Gray-coded line-pair commit pointer to the read domain, with data-available, frame-done and overflow status.

## Interface
Parameters:
- `COLUMNS`, 320: pixel-pair beats per input line.
- `FRAME_LINES`, 480: input lines per frame; must be a multiple of 4.
- `BANKS`, 20: RAM bank pairs (each pair is one even bank and one odd bank).
- `SLOTS_PER_BANK`, 6: line pairs stored per bank.
- `OS_INCREMENT`, 160: address offset per stored line pair (`COLUMNS/2`).
- `ADDR_WIDTH`, 10: RAM address width.

Ports:
- `clka`  in  1  write clock (CSI-2 byte clock).
- `write_rst_n`  in  1  reset, asynchronous, active-low; clock `clka`.
- `frame_start`  in  1  one-cycle pulse marking the first beat of a frame.
- `pix_valid`  in  1  `pix_data` valid this cycle.
- `pix_data`  in  16  pixel pair (two Bayer samples).
- `rd_ptr_gray`  in  8  read-domain consumed line-pair pointer, Gray-coded, asynchronous to `clka`.
- `wr_data`  out  16  registered copy of `pix_data`, aligned with the enables.
- `wr_addr`  out  ADDR_WIDTH  RAM address.
- `wr_sel`  out  5  bank pair index, 0..BANKS-1.
- `we_even`  out  1  write enable for the even bank of `wr_sel`.
- `we_odd`  out  1  write enable for the odd bank of `wr_sel`.
- `wr_ptr_gray`  out  8  committed line-pair count, mod 256, Gray-coded.
- `data_available`  out  1  at least one line pair committed since reset.
- `frame_done`  out  1  one-cycle pulse after the last commit of a frame.
- `overflow`  out  1  sticky flag: writer lapped the reader.

## Operation
- Counters:
  - `col` counts 0..COLUMNS-1 and advances on each `pix_valid`.
  - `lin` counts 0..FRAME_LINES-1 and advances when `col` wraps.
  - `slot` counts 0..5, together with `offset` and `sel`.
- Store condition: `col[0]==0 && lin[1]==0`.
  - `we_even` = store & `!lin[0]`; `we_odd` = store & `lin[0]`; both are qualified by `pix_valid`.
  - `wr_addr` = `(col>>1) + offset`, truncated to ADDR_WIDTH.
- Commit fires on a valid beat with `col==COLUMNS-1`, `lin[0]==1` and `lin[1]==0`. On commit:
  - `offset += OS_INCREMENT` and `slot++`.
  - If `slot==SLOTS_PER_BANK-1`: `offset=0`, `slot=0`, and `sel` advances, wrapping from BANKS-1 to 0.
  - The binary pointer `wr_ptr++` (8-bit, free-running), and `wr_ptr_gray` is updated.
  - `data_available` is set to 1 and holds until reset.
- One frame gives 120 commits, which equals BANKS×SLOTS_PER_BANK. At the frame's end, `sel`, `slot` and `offset` are therefore naturally back at 0.
- `frame_done` pulses on the commit where `lin==FRAME_LINES-3`, the last stored pair.
- `frame_start` synchronously clears `col`, `lin`, `slot`, `offset` and `sel`.
  - If it coincides with `pix_valid`, that beat is col 0 / line 0: it is stored and `col` becomes 1.
  - `wr_ptr`, `data_available` and `overflow` are not affected.
  - A mid-frame `frame_start` abandons the partial line pair with no commit.
- Overflow detection:
  - `rd_ptr_gray` passes through a 2-flop synchronizer and is converted to binary `rd_ptr`.
  - At commit, if `(wr_ptr - rd_ptr) mod 256 >= 120` before the increment, `overflow` is set (sticky).
  - Writing continues regardless, so the read side is never stalled.
- Beats with `pix_valid=0` do not change any counter.

## Timing
- Enables, address, select and data are registered, with 1-cycle latency from the `pix_valid` beat to `we_*`/`wr_addr`/`wr_data`.
- `we_even` and `we_odd` are never high together. Both are 0 on cycles that do not follow a stored valid beat.
- `wr_ptr_gray`, `data_available` and `frame_done` update in the cycle after the commit beat.
  - The last pair's writes use the pre-commit `sel`/`offset`.
  - The new `sel`/`offset` take effect on the next stored beat.
- `wr_ptr_gray` changes at most one bit per `clka` edge, so it is safe for two-flop capture in `clkb`.
- Synchronizer latency for `rd_ptr` is 2 `clka` cycles. The overflow check is therefore conservative by up to 2 cycles of reader progress.
- Reset, asynchronous assert and synchronous deassert: every output is 0, including `wr_addr`, `wr_sel`, `wr_data` and both enables. All counters, `wr_ptr` and the synchronizer flops also go to 0.
  - Reset mid-line discards the partial pair.

## Test plan
- Reset, then one line of 320 valid beats on line 0 → 160 `we_even` pulses, `wr_addr` 0..159, `wr_sel`=0, `we_odd` never high, `wr_ptr_gray`=0.
- Lines 0–3 continuous → line 1 writes `we_odd` at addresses 0..159. One cycle after the last beat of line 1, `wr_ptr_gray`=1 and `data_available`=1. Lines 2–3 produce no enables.
- Full 480-line frame with gaps in `pix_valid` → 120 commits, with `wr_sel` stepping 0..19 every 6 commits. `frame_done` pulses exactly once, `wr_ptr`=120, and `sel`/`offset` end at 0.
- `frame_start` asserted at col 100 of line 5 → the next beat writes `wr_addr`=0, `wr_sel`=0 via `we_even`, and `wr_ptr` is unchanged.
- `rd_ptr_gray` held at 0 for two frames → `overflow` rises at the 121st commit and stays set; writes continue.
- `write_rst_n` pulsed low mid-frame → all outputs 0 immediately. After release, the first line reproduces the first scenario.

Source files
------------

// File: rtl/csi_wr_sequencer_if.sv
// Pixel-pair stream in, line-buffer RAM write port out.
// The sequencer takes the slave side; the stream source/RAM model the master.
interface csi_wr_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  frame_start;
    logic                  pix_valid;
    logic [15:0]           pix_data;
    logic [15:0]           wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [4:0]            wr_sel;
    logic                  we_even;
    logic                  we_odd;

    modport slave (
        input  frame_start,
        input  pix_valid,
        input  pix_data,
        output wr_data,
        output wr_addr,
        output wr_sel,
        output we_even,
        output we_odd
    );

    modport master (
        output frame_start,
        output pix_valid,
        output pix_data,
        input  wr_data,
        input  wr_addr,
        input  wr_sel,
        input  we_even,
        input  we_odd
    );
endinterface

// File: rtl/csi_wr_sequencer.sv
// Write-side sequencer for the banked line buffer: store-2/skip-2 sub-sampling,
// registered RAM write port, Gray commit pointer and overflow status.
module csi_wr_sequencer #(
    parameter int COLUMNS        = 320,
    parameter int FRAME_LINES    = 480,
    parameter int BANKS          = 20,
    parameter int SLOTS_PER_BANK = 6,
    parameter int OS_INCREMENT   = 160,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic               clka,
    input  logic               write_rst_n,
    csi_wr_sequencer_if.slave  pix,
    input  logic [7:0]         rd_ptr_gray,
    output logic [7:0]         wr_ptr_gray,
    output logic               data_available,
    output logic               frame_done,
    output logic               overflow
);

    localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int LW = (FRAME_LINES > 4) ? $clog2(FRAME_LINES) : 2;
    localparam int SW = (SLOTS_PER_BANK > 1) ? $clog2(SLOTS_PER_BANK) : 1;
    localparam int CAPACITY = BANKS * SLOTS_PER_BANK;

    logic                  frame_start;
    logic                  pix_valid;
    logic [15:0]           pix_data;

    logic [CW-1:0]         col, col_e, col_nxt;
    logic [LW-1:0]         lin, lin_e, lin_nxt;
    logic [SW-1:0]         slot, slot_e, slot_nxt;
    logic [ADDR_WIDTH-1:0] offset, offset_e, offset_nxt;
    logic [4:0]            sel, sel_e, sel_nxt;

    logic                  col_wrap;
    logic                  lin_wrap;
    logic                  store;
    logic                  commit;
    logic                  last_pair;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    logic [7:0]            wr_ptr, wr_ptr_nxt;
    logic [7:0]            rd_sync1, rd_sync2;
    logic [7:0]            rd_ptr;
    logic [7:0]            occupancy;

    logic [15:0]           wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [4:0]            wr_sel_q;
    logic                  we_even_q;
    logic                  we_odd_q;

    assign frame_start = pix.frame_start;
    assign pix_valid   = pix.pix_valid;
    assign pix_data    = pix.pix_data;

    assign pix.wr_data = wr_data_q;
    assign pix.wr_addr = wr_addr_q;
    assign pix.wr_sel  = wr_sel_q;
    assign pix.we_even = we_even_q;
    assign pix.we_odd  = we_odd_q;

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // frame_start overrides the position so a coincident beat lands at 0/0
    always_comb begin
        col_e    = frame_start ? '0 : col;
        lin_e    = frame_start ? '0 : lin;
        slot_e   = frame_start ? '0 : slot;
        offset_e = frame_start ? '0 : offset;
        sel_e    = frame_start ? '0 : sel;

        col_wrap  = (col_e == CW'(COLUMNS - 1));
        lin_wrap  = (lin_e == LW'(FRAME_LINES - 1));
        store     = pix_valid && !col_e[0] && !lin_e[1];
        commit    = pix_valid && col_wrap && lin_e[0] && !lin_e[1];
        last_pair = (lin_e == LW'(FRAME_LINES - 3));
        addr_nxt  = ADDR_WIDTH'(col_e >> 1) + offset_e;

        rd_ptr     = gray2bin(rd_sync2);
        occupancy  = wr_ptr - rd_ptr;
        wr_ptr_nxt = wr_ptr + 8'd1;
    end

    always_comb begin
        col_nxt    = col_e;
        lin_nxt    = lin_e;
        slot_nxt   = slot_e;
        offset_nxt = offset_e;
        sel_nxt    = sel_e;
        if (pix_valid) begin
            col_nxt = col_wrap ? '0 : col_e + CW'(1);
            if (col_wrap) begin
                lin_nxt = lin_wrap ? '0 : lin_e + LW'(1);
            end
        end
        if (commit) begin
            if (slot_e == SW'(SLOTS_PER_BANK - 1)) begin
                slot_nxt   = '0;
                offset_nxt = '0;
                sel_nxt    = (sel_e == 5'(BANKS - 1)) ? 5'd0 : sel_e + 5'd1;
            end else begin
                slot_nxt   = slot_e + SW'(1);
                offset_nxt = offset_e + ADDR_WIDTH'(OS_INCREMENT);
            end
        end
    end

    always_ff @(posedge clka or negedge write_rst_n) begin
        if (!write_rst_n) begin
            col      <= '0;
            lin      <= '0;
            slot     <= '0;
            offset   <= '0;
            sel      <= '0;
            rd_sync1 <= '0;
            rd_sync2 <= '0;
        end else begin
            col      <= col_nxt;
            lin      <= lin_nxt;
            slot     <= slot_nxt;
            offset   <= offset_nxt;
            sel      <= sel_nxt;
            rd_sync1 <= rd_ptr_gray;
            rd_sync2 <= rd_sync1;
        end
    end

    // RAM port uses the pre-commit bank/offset for the beat that commits
    always_ff @(posedge clka or negedge write_rst_n) begin
        if (!write_rst_n) begin
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_sel_q  <= '0;
            we_even_q <= 1'b0;
            we_odd_q  <= 1'b0;
        end else begin
            we_even_q <= store && !lin_e[0];
            we_odd_q  <= store && lin_e[0];
            if (store) begin
                wr_data_q <= pix_data;
                wr_addr_q <= addr_nxt;
                wr_sel_q  <= sel_e;
            end
        end
    end

    always_ff @(posedge clka or negedge write_rst_n) begin
        if (!write_rst_n) begin
            wr_ptr         <= '0;
            wr_ptr_gray    <= '0;
            data_available <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            frame_done <= commit && last_pair;
            if (commit) begin
                wr_ptr         <= wr_ptr_nxt;
                wr_ptr_gray    <= wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
                data_available <= 1'b1;
                if (occupancy >= 8'(CAPACITY)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
